id_stage_piped: RTL and testbench

- Parametrised decode stage for the 5-stage MIPS pipeline, combined with its own ID/EX pipeline register.
- Decodes the instruction and resolves branches in ID.
- Detects load-use hazards against the instruction held in its own ID/EX register and inserts one bubble per hazard.
- Honours a downstream stall and a flush.
- Feeds the EX stage directly; drives the IF-stage freeze and the branch redirect.

---
 rtl/id_stage_piped.sv | 197 +++++++++++++++++++
 tb/tb_id_stage_piped.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_piped.sv
// Decode stage of the 5-stage MIPS pipeline with its own ID/EX register.
// Resolves branches in ID and inserts one bubble for each load-use hazard.
module id_stage_piped #(
    parameter int DATA_W      = 32,
    parameter int REG_AW      = 5,
    parameter bit LOAD_USE_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr,
    input  logic              instr_valid,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] reg1_data,
    input  logic [DATA_W-1:0] reg2_data,
    input  logic              stall_in,
    input  logic              flush,
    output logic [REG_AW-1:0] src1_addr,
    output logic [REG_AW-1:0] src2_addr,
    output logic              id_ready,
    output logic              br_taken,
    output logic [DATA_W-1:0] br_target,
    output logic              ex_valid,
    output logic [3:0]        ex_cmd,
    output logic              ex_mem_r_en,
    output logic              ex_mem_w_en,
    output logic              ex_wb_en,
    output logic [DATA_W-1:0] ex_val1,
    output logic [DATA_W-1:0] ex_val2,
    output logic [DATA_W-1:0] ex_st_data,
    output logic [REG_AW-1:0] ex_dest,
    output logic [REG_AW-1:0] ex_src1,
    output logic [REG_AW-1:0] ex_src2_fw,
    output logic [DATA_W-1:0] ex_pc
);

    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd3;
    localparam logic [5:0] OP_AND  = 6'd5;
    localparam logic [5:0] OP_OR   = 6'd6;
    localparam logic [5:0] OP_NOR  = 6'd7;
    localparam logic [5:0] OP_XOR  = 6'd8;
    localparam logic [5:0] OP_SLA  = 6'd9;
    localparam logic [5:0] OP_SLL  = 6'd10;
    localparam logic [5:0] OP_SRA  = 6'd11;
    localparam logic [5:0] OP_SRL  = 6'd12;
    localparam logic [5:0] OP_ADDI = 6'd32;
    localparam logic [5:0] OP_SUBI = 6'd33;
    localparam logic [5:0] OP_LD   = 6'd36;
    localparam logic [5:0] OP_ST   = 6'd37;
    localparam logic [5:0] OP_BEZ  = 6'd40;
    localparam logic [5:0] OP_BNE  = 6'd41;
    localparam logic [5:0] OP_JMP  = 6'd42;

    typedef struct packed {
        logic              valid;
        logic [3:0]        cmd;
        logic              mem_r;
        logic              mem_w;
        logic              wb;
        logic [DATA_W-1:0] val1;
        logic [DATA_W-1:0] val2;
        logic [DATA_W-1:0] st_data;
        logic [REG_AW-1:0] dest;
        logic [REG_AW-1:0] src1;
        logic [REG_AW-1:0] src2_fw;
        logic [DATA_W-1:0] pc;
    } idex_t;

    function automatic idex_t bubble_f();
        idex_t b;
        b     = '0;
        b.cmd = 4'b1111;
        return b;
    endfunction

    idex_t             idex_r;
    idex_t             idex_next_s;
    logic [5:0]        opcode_s;
    logic [3:0]        cmd_s;
    logic              wb_s;
    logic              mem_r_s;
    logic              mem_w_s;
    logic              imm_form_s;
    logic              src2_used_s;
    logic              src2_hi_s;
    logic              br_cond_s;
    logic              hazard_s;
    logic [DATA_W-1:0] imm_ext_s;

    assign opcode_s  = instr[31:26];
    assign imm_ext_s = {{(DATA_W-16){instr[15]}}, instr[15:0]};

    // Opcode decode into EXE command, control bits and branch condition
    always_comb begin
        cmd_s       = 4'b1111;
        wb_s        = 1'b0;
        mem_r_s     = 1'b0;
        mem_w_s     = 1'b0;
        imm_form_s  = 1'b0;
        src2_used_s = 1'b0;
        src2_hi_s   = 1'b0;
        br_cond_s   = 1'b0;
        case (opcode_s)
            OP_ADD: begin cmd_s = 4'b0000; wb_s = 1'b1; src2_used_s = 1'b1; end
            OP_SUB: begin cmd_s = 4'b0010; wb_s = 1'b1; src2_used_s = 1'b1; end
            OP_AND: begin cmd_s = 4'b0100; wb_s = 1'b1; src2_used_s = 1'b1; end
            OP_OR:  begin cmd_s = 4'b0101; wb_s = 1'b1; src2_used_s = 1'b1; end
            OP_NOR: begin cmd_s = 4'b0110; wb_s = 1'b1; src2_used_s = 1'b1; end
            OP_XOR: begin cmd_s = 4'b0111; wb_s = 1'b1; src2_used_s = 1'b1; end
            OP_SLA, OP_SLL: begin cmd_s = 4'b1000; wb_s = 1'b1; src2_used_s = 1'b1; end
            OP_SRA: begin cmd_s = 4'b1001; wb_s = 1'b1; src2_used_s = 1'b1; end
            OP_SRL: begin cmd_s = 4'b1010; wb_s = 1'b1; src2_used_s = 1'b1; end
            OP_ADDI: begin cmd_s = 4'b0000; wb_s = 1'b1; imm_form_s = 1'b1; end
            OP_SUBI: begin cmd_s = 4'b0010; wb_s = 1'b1; imm_form_s = 1'b1; end
            OP_LD: begin
                cmd_s      = 4'b0000;
                wb_s       = 1'b1;
                mem_r_s    = 1'b1;
                imm_form_s = 1'b1;
            end
            OP_ST: begin
                cmd_s       = 4'b0000;
                mem_w_s     = 1'b1;
                imm_form_s  = 1'b1;
                src2_used_s = 1'b1;
                src2_hi_s   = 1'b1;
            end
            OP_BEZ: br_cond_s = (reg1_data == {DATA_W{1'b0}});
            OP_BNE: begin
                br_cond_s   = (reg1_data != reg2_data);
                src2_used_s = 1'b1;
                src2_hi_s   = 1'b1;
            end
            OP_JMP:  br_cond_s = 1'b1;
            default: cmd_s = 4'b1111;
        endcase
    end

    // ST and BNE read their second operand from the destination field
    assign src1_addr = instr[20:16];
    assign src2_addr = src2_hi_s ? instr[25:21] : instr[15:11];

    assign hazard_s = LOAD_USE_EN && idex_r.valid && idex_r.mem_r &&
                      (idex_r.dest != {REG_AW{1'b0}}) &&
                      ((idex_r.dest == src1_addr) ||
                       (src2_used_s && (idex_r.dest == src2_addr)));

    assign id_ready  = !(stall_in || hazard_s);
    assign br_target = pc_in + (imm_ext_s << 2);
    assign br_taken  = rst && br_cond_s && instr_valid && !flush && !hazard_s && !stall_in;

    // Next ID/EX content: bubble for flush, hazard or empty slot, else decoded instr
    always_comb begin
        idex_next_s = bubble_f();
        if (flush || hazard_s || !instr_valid) begin
            idex_next_s = bubble_f();
        end else begin
            idex_next_s.valid   = 1'b1;
            idex_next_s.cmd     = cmd_s;
            idex_next_s.mem_r   = mem_r_s;
            idex_next_s.mem_w   = mem_w_s;
            idex_next_s.wb      = wb_s;
            idex_next_s.val1    = reg1_data;
            idex_next_s.val2    = imm_form_s ? imm_ext_s : reg2_data;
            idex_next_s.st_data = mem_w_s ? reg2_data : {DATA_W{1'b0}};
            idex_next_s.dest    = instr[25:21];
            idex_next_s.src1    = src1_addr;
            idex_next_s.src2_fw = imm_form_s ? {REG_AW{1'b0}} : src2_addr;
            idex_next_s.pc      = pc_in;
        end
    end

    // ID/EX register: a downstream stall holds it, flush included
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idex_r <= bubble_f();
        end else if (stall_in) begin
            idex_r <= idex_r;
        end else begin
            idex_r <= idex_next_s;
        end
    end

    assign ex_valid    = idex_r.valid;
    assign ex_cmd      = idex_r.cmd;
    assign ex_mem_r_en = idex_r.mem_r;
    assign ex_mem_w_en = idex_r.mem_w;
    assign ex_wb_en    = idex_r.wb;
    assign ex_val1     = idex_r.val1;
    assign ex_val2     = idex_r.val2;
    assign ex_st_data  = idex_r.st_data;
    assign ex_dest     = idex_r.dest;
    assign ex_src1     = idex_r.src1;
    assign ex_src2_fw  = idex_r.src2_fw;
    assign ex_pc       = idex_r.pc;

endmodule

// File: tb/tb_id_stage_piped.sv
// Bench for id_stage_piped: directed table, stall/flush/reset sequences and
// random traffic against a reference model, for LOAD_USE_EN = 1 and 0.
module tb_id_stage_piped;

    typedef struct {
        logic        valid;
        logic [3:0]  cmd;
        logic        mr, mw, wb;
        logic [31:0] val1, val2, st;
        logic [4:0]  dest, src1, src2fw;
        logic [31:0] pc;
    } ex_t;

    typedef struct {
        logic [31:0] instr;
        bit          valid, flush;
        logic [31:0] pc, r1, r2;
        bit          e_ready, e_br;
        logic [31:0] e_tgt;
        bit          e_valid;
        logic [3:0]  e_cmd;
        logic [31:0] e_val1, e_val2;
        logic [4:0]  e_dest;
        bit          e_wb;
    } vec_t;

    logic clk, rst_n;
    logic [31:0] instr, pc_in, reg1_data, reg2_data;
    logic instr_valid, stall_in, flush;

    logic [4:0]  a_src1, a_src2, a_dest, a_src1e, a_src2fw;
    logic        a_ready, a_br, a_ex_valid, a_mr, a_mw, a_wb;
    logic [3:0]  a_cmd;
    logic [31:0] a_tgt, a_val1, a_val2, a_st, a_pc;
    logic [4:0]  b_src1, b_src2, b_dest, b_src1e, b_src2fw;
    logic        b_ready, b_br, b_ex_valid, b_mr, b_mw, b_wb;
    logic [3:0]  b_cmd;
    logic [31:0] b_tgt, b_val1, b_val2, b_st, b_pc;

    int vectors = 0;
    int miscompares = 0;
    ex_t st_a, st_b;
    logic [3:0] cmd_lut [0:63];
    vec_t tbl [10];

    id_stage_piped #(.DATA_W(32), .REG_AW(5), .LOAD_USE_EN(1'b1)) dut (
        .clk(clk), .rst(rst_n), .instr(instr), .instr_valid(instr_valid), .pc_in(pc_in),
        .reg1_data(reg1_data), .reg2_data(reg2_data), .stall_in(stall_in), .flush(flush),
        .src1_addr(a_src1), .src2_addr(a_src2), .id_ready(a_ready), .br_taken(a_br),
        .br_target(a_tgt), .ex_valid(a_ex_valid), .ex_cmd(a_cmd), .ex_mem_r_en(a_mr),
        .ex_mem_w_en(a_mw), .ex_wb_en(a_wb), .ex_val1(a_val1), .ex_val2(a_val2),
        .ex_st_data(a_st), .ex_dest(a_dest), .ex_src1(a_src1e), .ex_src2_fw(a_src2fw),
        .ex_pc(a_pc));

    id_stage_piped #(.DATA_W(32), .REG_AW(5), .LOAD_USE_EN(1'b0)) dut_nl (
        .clk(clk), .rst(rst_n), .instr(instr), .instr_valid(instr_valid), .pc_in(pc_in),
        .reg1_data(reg1_data), .reg2_data(reg2_data), .stall_in(stall_in), .flush(flush),
        .src1_addr(b_src1), .src2_addr(b_src2), .id_ready(b_ready), .br_taken(b_br),
        .br_target(b_tgt), .ex_valid(b_ex_valid), .ex_cmd(b_cmd), .ex_mem_r_en(b_mr),
        .ex_mem_w_en(b_mw), .ex_wb_en(b_wb), .ex_val1(b_val1), .ex_val2(b_val2),
        .ex_st_data(b_st), .ex_dest(b_dest), .ex_src1(b_src1e), .ex_src2_fw(b_src2fw),
        .ex_pc(b_pc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk_r(input int op, input int rd, input int rs1, input int rs2);
        return {6'(op), 5'(rd), 5'(rs1), 5'(rs2), 11'd0};
    endfunction

    function automatic logic [31:0] mk_i(input int op, input int rd, input int rs1, input logic [15:0] imm);
        return {6'(op), 5'(rd), 5'(rs1), imm};
    endfunction

    function automatic ex_t bubble();
        ex_t b;
        b = '{default: '0};
        b.cmd = 4'hF;
        return b;
    endfunction

    function automatic ex_t act_ex(input bit which);
        ex_t e;
        if (!which) begin
            e = '{a_ex_valid, a_cmd, a_mr, a_mw, a_wb, a_val1, a_val2, a_st, a_dest, a_src1e, a_src2fw, a_pc};
        end else begin
            e = '{b_ex_valid, b_cmd, b_mr, b_mw, b_wb, b_val1, b_val2, b_st, b_dest, b_src1e, b_src2fw, b_pc};
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_ex(input string tag, input ex_t a, input ex_t e);
        chk({tag, ".ex_valid"}, 32'(a.valid), 32'(e.valid));
        chk({tag, ".ex_cmd"}, 32'(a.cmd), 32'(e.cmd));
        chk({tag, ".ex_mem_r_en"}, 32'(a.mr), 32'(e.mr));
        chk({tag, ".ex_mem_w_en"}, 32'(a.mw), 32'(e.mw));
        chk({tag, ".ex_wb_en"}, 32'(a.wb), 32'(e.wb));
        chk({tag, ".ex_val1"}, a.val1, e.val1);
        chk({tag, ".ex_val2"}, a.val2, e.val2);
        chk({tag, ".ex_st_data"}, a.st, e.st);
        chk({tag, ".ex_dest"}, 32'(a.dest), 32'(e.dest));
        chk({tag, ".ex_src1"}, 32'(a.src1), 32'(e.src1));
        chk({tag, ".ex_src2_fw"}, 32'(a.src2fw), 32'(e.src2fw));
        chk({tag, ".ex_pc"}, a.pc, e.pc);
    endtask

    // Reference: the spec's opcode rules applied to the current inputs and model state
    task automatic model_step(input bit lu, input ex_t cur, output bit ready, output bit br,
                              output logic [31:0] tgt, output logic [4:0] s1, output logic [4:0] s2,
                              output ex_t nxt);
        logic [5:0]  op;
        bit          alu, immf, uses2, haz, cond;
        logic [31:0] imm;
        op = instr[31:26];
        if (!(op inside {6'd0, 6'd1, 6'd3, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10, 6'd11, 6'd12,
                         6'd32, 6'd33, 6'd36, 6'd37, 6'd40, 6'd41, 6'd42})) op = 6'd0;
        alu   = op inside {6'd1, 6'd3, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10, 6'd11, 6'd12};
        immf  = op inside {6'd32, 6'd33, 6'd36, 6'd37};
        uses2 = alu || op == 6'd37 || op == 6'd41;
        s1    = instr[20:16];
        s2    = (op == 6'd37 || op == 6'd41) ? instr[25:21] : instr[15:11];
        haz   = lu && cur.valid && cur.mr && cur.dest != 5'd0 &&
                (cur.dest == s1 || (uses2 && cur.dest == s2));
        cond  = (op == 6'd40 && reg1_data == 32'd0) || (op == 6'd41 && reg1_data != reg2_data) ||
                (op == 6'd42);
        imm   = {{16{instr[15]}}, instr[15:0]};
        tgt   = pc_in + imm * 32'd4;
        ready = !(stall_in || haz);
        br    = cond && instr_valid && !flush && !haz && !stall_in;
        if (stall_in) nxt = cur;
        else if (flush || haz || !instr_valid) nxt = bubble();
        else begin
            nxt = '{1'b1, cmd_lut[op], op == 6'd36, op == 6'd37,
                    alu || op inside {6'd32, 6'd33, 6'd36},
                    reg1_data, immf ? imm : reg2_data, (op == 6'd37) ? reg2_data : 32'd0,
                    instr[25:21], s1, immf ? 5'd0 : s2, pc_in};
        end
    endtask

    // One cycle from a negedge with inputs applied: combinational then registered checks
    task automatic run_cycle();
        ex_t na, nb;
        bit ra, rb, ba, bb;
        logic [31:0] ta, tb2;
        logic [4:0] s1, s2, s1b, s2b;
        #1;
        model_step(1'b1, st_a, ra, ba, ta, s1, s2, na);
        model_step(1'b0, st_b, rb, bb, tb2, s1b, s2b, nb);
        chk("a.id_ready", 32'(a_ready), 32'(ra));
        chk("a.br_taken", 32'(a_br), 32'(ba));
        chk("a.br_target", a_tgt, ta);
        chk("a.src1_addr", 32'(a_src1), 32'(s1));
        chk("a.src2_addr", 32'(a_src2), 32'(s2));
        chk("b.id_ready", 32'(b_ready), 32'(rb));
        chk("b.br_taken", 32'(b_br), 32'(bb));
        @(posedge clk);
        #1;
        chk_ex("a", act_ex(1'b0), na);
        chk_ex("b", act_ex(1'b1), nb);
        st_a = na;
        st_b = nb;
        @(negedge clk);
    endtask

    task automatic set_in(input logic [31:0] i, input bit v, input logic [31:0] pc,
                          input logic [31:0] r1, input logic [31:0] r2, input bit s, input bit f);
        instr = i; instr_valid = v; pc_in = pc; reg1_data = r1; reg2_data = r2;
        stall_in = s; flush = f;
    endtask

    initial begin
        ex_t na, nb;
        bit ra, rb, ba, bb;
        logic [31:0] ta, tb2;
        logic [4:0] s1, s2, s1b, s2b;
        logic [5:0] ops [20] = '{6'd0, 6'd1, 6'd3, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10, 6'd11,
                                 6'd12, 6'd32, 6'd33, 6'd36, 6'd37, 6'd40, 6'd41, 6'd42, 6'd2, 6'd63};

        for (int i = 0; i < 64; i++) cmd_lut[i] = 4'hF;
        cmd_lut[1] = 4'h0;  cmd_lut[32] = 4'h0; cmd_lut[36] = 4'h0; cmd_lut[37] = 4'h0;
        cmd_lut[3] = 4'h2;  cmd_lut[33] = 4'h2; cmd_lut[5] = 4'h4;  cmd_lut[6] = 4'h5;
        cmd_lut[7] = 4'h6;  cmd_lut[8] = 4'h7;  cmd_lut[9] = 4'h8;  cmd_lut[10] = 4'h8;
        cmd_lut[11] = 4'h9; cmd_lut[12] = 4'hA;

        //            instr                        v  f  pc   r1   r2  rdy br tgt    ev cmd  val1 val2 dst wb
        tbl[0] = '{mk_r(1, 3, 1, 2),           1, 0, 100,   5,  7, 1, 0, 16484, 1, 4'h0,   5,  7, 3, 1};
        tbl[1] = '{mk_i(36, 4, 1, 16'd8),      1, 0, 104, 100,  9, 1, 0,   136, 1, 4'h0, 100,  8, 4, 1};
        tbl[2] = '{mk_r(1, 5, 4, 1),           1, 0, 108,  11, 22, 0, 0,  8300, 0, 4'hF,   0,  0, 0, 0};
        tbl[3] = '{mk_r(1, 5, 4, 1),           1, 0, 108,  11, 22, 1, 0,  8300, 1, 4'h0,  11, 22, 5, 1};
        tbl[4] = '{mk_i(41, 6, 7, 16'hFFFF),   1, 0, 200,   3,  4, 1, 1,   196, 1, 4'hF,   3,  4, 6, 0};
        tbl[5] = '{mk_i(41, 6, 7, 16'hFFFF),   1, 0, 200,   3,  3, 1, 0,   196, 1, 4'hF,   3,  3, 6, 0};
        tbl[6] = '{mk_i(32, 2, 9, 16'hFFFF),   1, 1, 300,  50,  0, 1, 0,   296, 0, 4'hF,   0,  0, 0, 0};
        tbl[7] = '{mk_i(42, 0, 0, 16'd0),      0, 0, 400,   1,  2, 1, 0,   400, 0, 4'hF,   0,  0, 0, 0};
        tbl[8] = '{mk_i(42, 0, 0, 16'd0),      1, 0, 400,   1,  2, 1, 1,   400, 1, 4'hF,   1,  2, 0, 0};
        tbl[9] = '{mk_i(63, 7, 0, 16'd0),      1, 0, 500,   0,  0, 1, 0,   500, 1, 4'hF,   0,  0, 7, 0};

        // Reset: register cleared, br_taken forced low even for a valid JMP
        rst_n = 1'b0;
        set_in(mk_i(42, 0, 0, 16'd0), 1'b1, 32'd40, 32'd1, 32'd2, 1'b0, 1'b0);
        #12;
        chk("rst.ex_valid", 32'(a_ex_valid), 32'd0);
        chk("rst.ex_cmd", 32'(a_cmd), 32'hF);
        chk("rst.ex_wb_en", 32'(a_wb), 32'd0);
        chk("rst.ex_pc", a_pc, 32'd0);
        chk("rst.br_taken", 32'(a_br), 32'd0);
        chk("rst.br_target", a_tgt, 32'd40);
        @(negedge clk);
        rst_n = 1'b1;
        st_a = bubble();
        st_b = bubble();

        // Directed table
        for (int i = 0; i < 10; i++) begin
            set_in(tbl[i].instr, tbl[i].valid, tbl[i].pc, tbl[i].r1, tbl[i].r2, 1'b0, tbl[i].flush);
            #1;
            chk($sformatf("tbl%0d.id_ready", i), 32'(a_ready), 32'(tbl[i].e_ready));
            chk($sformatf("tbl%0d.br_taken", i), 32'(a_br), 32'(tbl[i].e_br));
            chk($sformatf("tbl%0d.br_target", i), a_tgt, tbl[i].e_tgt);
            chk($sformatf("tbl%0d.nl_id_ready", i), 32'(b_ready), 32'd1);
            model_step(1'b1, st_a, ra, ba, ta, s1, s2, na);
            model_step(1'b0, st_b, rb, bb, tb2, s1b, s2b, nb);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d.ex_valid", i), 32'(a_ex_valid), 32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d.ex_cmd", i), 32'(a_cmd), 32'(tbl[i].e_cmd));
            chk($sformatf("tbl%0d.ex_val1", i), a_val1, tbl[i].e_val1);
            chk($sformatf("tbl%0d.ex_val2", i), a_val2, tbl[i].e_val2);
            chk($sformatf("tbl%0d.ex_dest", i), 32'(a_dest), 32'(tbl[i].e_dest));
            chk($sformatf("tbl%0d.ex_wb_en", i), 32'(a_wb), 32'(tbl[i].e_wb));
            chk_ex($sformatf("tbl%0d.nl", i), act_ex(1'b1), nb);
            st_a = na;
            st_b = nb;
            @(negedge clk);
        end

        // Stall for three cycles with changing instructions: ID/EX frozen
        set_in(mk_r(1, 3, 1, 2), 1'b1, 32'd600, 32'd5, 32'd7, 1'b0, 1'b0);
        run_cycle();
        for (int k = 0; k < 3; k++) begin
            set_in((k == 1) ? mk_i(42, 0, 0, 16'd4) : mk_r(3, k + 8, k, k + 1), 1'b1,
                   32'd700 + 32'(k), $urandom, $urandom, 1'b1, 1'b0);
            run_cycle();
            chk("stall.ex_val1", a_val1, 32'd5);
            chk("stall.ex_cmd", 32'(a_cmd), 32'h0);
            chk("stall.ex_dest", 32'(a_dest), 32'd3);
            chk("stall.id_ready", 32'(a_ready), 32'd0);
            chk("stall.br_taken", 32'(a_br), 32'd0);
        end
        // Flush under stall is ignored; flush alone kills the ADDI
        set_in(mk_i(32, 2, 9, 16'd3), 1'b1, 32'd800, 32'd9, 32'd9, 1'b1, 1'b1);
        run_cycle();
        chk("flushstall.ex_valid", 32'(a_ex_valid), 32'd1);
        chk("flushstall.ex_val1", a_val1, 32'd5);
        set_in(mk_i(32, 2, 9, 16'd3), 1'b1, 32'd800, 32'd9, 32'd9, 1'b0, 1'b1);
        run_cycle();
        chk("flush.ex_valid", 32'(a_ex_valid), 32'd0);
        chk("flush.ex_wb_en", 32'(a_wb), 32'd0);

        // Asynchronous reset mid-cycle while stalled
        set_in(mk_i(36, 6, 1, 16'd0), 1'b1, 32'd900, 32'd1, 32'd2, 1'b0, 1'b0);
        run_cycle();
        set_in(mk_i(42, 0, 5, 16'd1), 1'b1, 32'd1000, 32'd1, 32'd2, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.ex_valid", 32'(a_ex_valid), 32'd0);
        chk("arst.ex_cmd", 32'(a_cmd), 32'hF);
        chk("arst.ex_mem_r_en", 32'(a_mr), 32'd0);
        chk("arst.ex_val1", a_val1, 32'd0);
        chk("arst.br_taken", 32'(a_br), 32'd0);
        chk("arst.src1_addr", 32'(a_src1), 32'd5);
        st_a = bubble();
        st_b = bubble();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stall_in = 1'b0;
        run_cycle();

        // Random traffic against the reference model
        for (int n = 0; n < 1500; n++) begin
            logic [5:0] op;
            op = ops[$urandom_range(0, 19)];
            if ($urandom_range(0, 3) == 0) op = 6'd36;
            instr       = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                           5'($urandom_range(0, 3)), 11'($urandom)};
            instr_valid = ($urandom_range(0, 7) != 0);
            stall_in    = ($urandom_range(0, 5) == 0);
            flush       = ($urandom_range(0, 7) == 0);
            pc_in       = $urandom;
            reg1_data   = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            reg2_data   = ($urandom_range(0, 3) == 0) ? reg1_data : $urandom;
            run_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
